chan_deserializer: RTL and testbench

//  Inter-layer link between a conv/fc stage's serial function-unit output (one channel value per

---
 rtl/chan_deserializer_if.sv | 27 ++
 rtl/chan_deserializer.sv | 97 +++++++++
 tb/tb_chan_deserializer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/chan_deserializer_if.sv
// Link bundle between a serial function-unit output, the deserializer,
// and the per-channel input-buffer write ports of the downstream stage.
interface chan_deserializer_if #(
  parameter int CHANNELS = 96,
  parameter int DATA_W   = 2
);
  logic                             i_valid;
  logic [DATA_W-1:0]                i_func_data;
  logic                             o_busy;
  logic                             i_down_busy;
  logic [CHANNELS-1:0]              o_ibuf_we;
  logic [CHANNELS-1:0][DATA_W-1:0]  o_ibuf_wr_data;
  logic                             o_start;
  logic                             o_frame_done;

  // Deserializer side
  modport slave (
    input  i_valid, i_func_data, i_down_busy,
    output o_busy, o_ibuf_we, o_ibuf_wr_data, o_start, o_frame_done
  );

  // Environment side: the upstream producer and the downstream consumer
  modport master (
    output i_valid, i_func_data, i_down_busy,
    input  o_busy, o_ibuf_we, o_ibuf_wr_data, o_start, o_frame_done
  );
endinterface

// File: rtl/chan_deserializer.sv
// Collects CHANNELS serial values into a shadow register. It then writes
// all values to the downstream per-channel ibufs in one cycle and pulses
// start. Upstream is back-pressured from the last accepted value until
// the start pulse is issued.
module chan_deserializer #(
  parameter int CHANNELS  = 96,
  parameter int DATA_W    = 2,
  parameter int IMG_WIDTH = 55
) (
  input  logic               clk,
  input  logic               rst,
  chan_deserializer_if.slave bus
);

  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PIX_W = (IMG_WIDTH * IMG_WIDTH > 1) ? $clog2(IMG_WIDTH * IMG_WIDTH) : 1;

  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);
  localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(IMG_WIDTH * IMG_WIDTH - 1);

  localparam logic [1:0] S_COLLECT = 2'd0;
  localparam logic [1:0] S_WRITE   = 2'd1;
  localparam logic [1:0] S_START   = 2'd2;

  logic [1:0]                      r_state;
  logic [CH_W-1:0]                 r_ch_cnt;
  logic [PIX_W-1:0]                r_pix_cnt;
  logic [CHANNELS-1:0][DATA_W-1:0] r_shadow;
  logic [CHANNELS-1:0]             r_ibuf_we;
  logic [CHANNELS-1:0][DATA_W-1:0] r_wr_data;
  logic                            r_start;
  logic                            r_frame_done;

  logic w_busy;
  logic w_accept;

  // Back-pressure is combinational so upstream sees it in the same cycle
  assign w_busy   = (r_state != S_COLLECT);
  assign w_accept = bus.i_valid && !w_busy;

  assign bus.o_busy         = w_busy;
  assign bus.o_ibuf_we      = r_ibuf_we;
  assign bus.o_ibuf_wr_data = r_wr_data;
  assign bus.o_start        = r_start;
  assign bus.o_frame_done   = r_frame_done;

  // Collect -> write -> start sequencing, with the channel and pixel counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_COLLECT;
      r_ch_cnt     <= '0;
      r_pix_cnt    <= '0;
      r_shadow     <= '0;
      r_ibuf_we    <= '0;
      r_wr_data    <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_ibuf_we    <= '0;
      r_start      <= 1'b0;
      r_frame_done <= 1'b0;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            r_shadow[r_ch_cnt] <= bus.i_func_data;
            if (r_ch_cnt == CH_LAST) begin
              r_ch_cnt <= '0;
              r_state  <= S_WRITE;
            end else begin
              r_ch_cnt <= r_ch_cnt + CH_W'(1);
            end
          end
        end
        S_WRITE: begin
          // A busy downstream stalls here indefinitely; the write data register keeps the previous pixel
          if (!bus.i_down_busy) begin
            r_ibuf_we <= '1;
            r_wr_data <= r_shadow;
            r_state   <= S_START;
          end
        end
        S_START: begin
          r_start <= 1'b1;
          if (r_pix_cnt == PIX_LAST) begin
            r_frame_done <= 1'b1;
            r_pix_cnt    <= '0;
          end else begin
            r_pix_cnt <= r_pix_cnt + PIX_W'(1);
          end
          r_state <= S_COLLECT;
        end
        default: r_state <= S_COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_chan_deserializer.sv
// Directed testbench for chan_deserializer with 4 channels, 2-bit values
// and a 2x2 frame.
module tb_chan_deserializer;

  localparam int CHANNELS  = 4;
  localparam int DATA_W    = 2;
  localparam int IMG_WIDTH = 2;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  chan_deserializer_if #(.CHANNELS(CHANNELS), .DATA_W(DATA_W)) bus ();

  chan_deserializer #(
    .CHANNELS (CHANNELS),
    .DATA_W   (DATA_W),
    .IMG_WIDTH(IMG_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one pixel (ch0 first) and check the write/start sequence that follows
  task automatic send_pixel(input string tag, input logic [7:0] pix, input logic exp_fd, input bit gap);
    for (int k = 0; k < CHANNELS; k++) begin
      bus.i_valid     = 1'b1;
      bus.i_func_data = pix[k*2 +: 2];
      step();
      if (gap && k != CHANNELS - 1) begin
        bus.i_valid     = 1'b0;
        bus.i_func_data = ~pix[k*2 +: 2];
        step();
      end
    end
    bus.i_valid = 1'b0;
    chk({tag, " busy_after_last"}, 32'(bus.o_busy), 32'd1);
    chk({tag, " we_after_last"}, 32'(bus.o_ibuf_we), 32'h0);
    step();
    chk({tag, " we"}, 32'(bus.o_ibuf_we), 32'hF);
    chk({tag, " wr_data"}, 32'(bus.o_ibuf_wr_data), 32'(pix));
    chk({tag, " busy_at_we"}, 32'(bus.o_busy), 32'd1);
    chk({tag, " start_at_we"}, 32'(bus.o_start), 32'd0);
    step();
    chk({tag, " we_off"}, 32'(bus.o_ibuf_we), 32'h0);
    chk({tag, " start"}, 32'(bus.o_start), 32'd1);
    chk({tag, " frame_done"}, 32'(bus.o_frame_done), 32'(exp_fd));
    chk({tag, " busy_at_start"}, 32'(bus.o_busy), 32'd0);
    step();
    chk({tag, " start_off"}, 32'(bus.o_start), 32'd0);
    chk({tag, " fd_off"}, 32'(bus.o_frame_done), 32'd0);
    chk({tag, " data_hold"}, 32'(bus.o_ibuf_wr_data), 32'(pix));
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    bus.i_valid     = 1'b0;
    bus.i_func_data = '0;
    bus.i_down_busy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset we", 32'(bus.o_ibuf_we), 32'h0);
    chk("reset data", 32'(bus.o_ibuf_wr_data), 32'h0);
    chk("reset start", 32'(bus.o_start), 32'd0);
    chk("reset fd", 32'(bus.o_frame_done), 32'd0);
    chk("reset busy", 32'(bus.o_busy), 32'd0);

    // Case 1: values 1,2,3,0 -> {0,3,2,1} = 8'h39, pixel 0
    send_pixel("c1", 8'h39, 1'b0, 1'b0);

    // Case 2: downstream busy stalls the write for 10 cycles (pixel 1)
    for (int k = 0; k < CHANNELS; k++) begin
      bus.i_valid     = 1'b1;
      bus.i_func_data = 2'(k);
      if (k == CHANNELS - 1) bus.i_down_busy = 1'b1;
      step();
    end
    bus.i_valid = 1'b0;
    for (int c = 0; c < 10; c++) begin
      chk("c2 stall busy", 32'(bus.o_busy), 32'd1);
      chk("c2 stall we", 32'(bus.o_ibuf_we), 32'h0);
      chk("c2 stall start", 32'(bus.o_start), 32'd0);
      step();
    end
    bus.i_down_busy = 1'b0;
    step();
    chk("c2 we", 32'(bus.o_ibuf_we), 32'hF);
    chk("c2 data", 32'(bus.o_ibuf_wr_data), 32'hE4);
    chk("c2 busy_at_we", 32'(bus.o_busy), 32'd1);
    step();
    chk("c2 start", 32'(bus.o_start), 32'd1);
    chk("c2 fd", 32'(bus.o_frame_done), 32'd0);
    chk("c2 busy_drop", 32'(bus.o_busy), 32'd0);

    // Case 3: valid held high with changing data while busy (pixels 2 and 3)
    bus.i_valid = 1'b1;
    bus.i_func_data = 2'd3; step();
    bus.i_func_data = 2'd2; step();
    bus.i_func_data = 2'd1; step();
    bus.i_func_data = 2'd0; step();
    bus.i_func_data = 2'd1; step();
    chk("c3a we", 32'(bus.o_ibuf_we), 32'hF);
    chk("c3a data", 32'(bus.o_ibuf_wr_data), 32'h1B);
    bus.i_func_data = 2'd2; step();
    chk("c3a start", 32'(bus.o_start), 32'd1);
    chk("c3a fd", 32'(bus.o_frame_done), 32'd0);
    chk("c3a busy", 32'(bus.o_busy), 32'd0);
    bus.i_func_data = 2'd3; step();
    bus.i_func_data = 2'd0; step();
    bus.i_func_data = 2'd0; step();
    bus.i_func_data = 2'd0; step();
    bus.i_valid = 1'b0;
    step();
    chk("c3b we", 32'(bus.o_ibuf_we), 32'hF);
    chk("c3b data", 32'(bus.o_ibuf_wr_data), 32'h03);
    step();
    chk("c3b start", 32'(bus.o_start), 32'd1);
    chk("c3b fd", 32'(bus.o_frame_done), 32'd1);
    step();
    chk("c3b fd_off", 32'(bus.o_frame_done), 32'd0);

    // Case 4: a full frame of four pixels, then one more after the wrap
    send_pixel("c4 p0", 8'hA5, 1'b0, 1'b0);
    send_pixel("c4 p1", 8'h5A, 1'b0, 1'b0);
    send_pixel("c4 p2", 8'hFF, 1'b0, 1'b0);
    send_pixel("c4 p3", 8'h00, 1'b1, 1'b0);
    send_pixel("c4 p4", 8'hC6, 1'b0, 1'b0);

    // Case 5: async reset after two values of a pixel
    bus.i_valid = 1'b1;
    bus.i_func_data = 2'd3; step();
    bus.i_func_data = 2'd3; step();
    bus.i_valid = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    chk("c5 rst data", 32'(bus.o_ibuf_wr_data), 32'h0);
    chk("c5 rst we", 32'(bus.o_ibuf_we), 32'h0);
    chk("c5 rst start", 32'(bus.o_start), 32'd0);
    chk("c5 rst busy", 32'(bus.o_busy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    send_pixel("c5 p0", 8'h39, 1'b0, 1'b0);
    send_pixel("c5 p1", 8'h12, 1'b0, 1'b0);
    send_pixel("c5 p2", 8'h34, 1'b0, 1'b0);
    send_pixel("c5 p3", 8'h56, 1'b1, 1'b0);

    // Case 6: valid every other cycle, same result as case 1
    send_pixel("c6", 8'h39, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Hard bound on run time
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
